// File: rtl/mcs4_ram_chip.sv
// MCS-4 data-RAM chip (4002 equivalent) bus responder: 4 regs x (16 main + 4 status) nibbles.
// Optional host inspection port enabled by defining MCS4_RAM_DBG_PORT_EN.
module mcs4_ram_chip #(
    parameter logic [1:0] CHIP_ID = 2'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sync_i,
    input  logic       cm_ram_i,
    input  logic [3:0] data_i,
    output logic [3:0] data_o,
    output logic       data_oe,
    output logic [3:0] port_o
`ifdef MCS4_RAM_DBG_PORT_EN
    ,
    input  logic [6:0] dbg_addr_i,
    output logic [3:0] dbg_data_o
`endif
);

    typedef enum logic [2:0] {PhA1, PhA2, PhA3, PhM1, PhM2, PhX1, PhX2, PhX3} phase_e;

    phase_e     phase_q, phase_d;
    logic       running_q, running_d;
    logic [3:0] opr_q, opr_d, opa_q, opa_d;
    logic       io_cmd_q, io_cmd_d;
    logic       src_x3_q, src_x3_d;
    logic       sel_q, sel_d;
    logic [1:0] ram_reg_q, ram_reg_d;
    logic [3:0] char_q, char_d;
    logic [3:0] data_q, data_d;
    logic       oe_q, oe_d;
    logic [3:0] port_q;
    logic       main_we, stat_we, port_we;

    logic [3:0] main_q   [4][16];
    logic [3:0] status_q [4][4];

    logic       early, dec, act, rd_main, rd_stat;
    logic [3:0] main_rd, stat_rd;

    // A sync outside X3 aborts the instruction in flight, including that cycle's decode.
    assign early   = sync_i && (phase_q != PhX3);
    assign dec     = running_q && !early;
    assign act     = dec && io_cmd_q && sel_q;
    assign rd_main = (opa_q == 4'b1001) || (opa_q == 4'b1000) || (opa_q == 4'b1011);
    assign rd_stat = (opa_q[3:2] == 2'b11);
    assign main_rd = main_q[ram_reg_q][char_q];
    assign stat_rd = status_q[ram_reg_q][opa_q[1:0]];

    always_comb begin
        phase_d   = phase_q;
        running_d = running_q;
        opr_d     = opr_q;
        opa_d     = opa_q;
        io_cmd_d  = io_cmd_q;
        src_x3_d  = src_x3_q;
        sel_d     = sel_q;
        ram_reg_d = ram_reg_q;
        char_d    = char_q;
        data_d    = data_q;
        oe_d      = 1'b0;
        main_we   = 1'b0;
        stat_we   = 1'b0;
        port_we   = 1'b0;

        if (sync_i) begin
            running_d = 1'b1;
            phase_d   = PhA1;
        end else if (running_q) begin
            phase_d = phase_e'(phase_q + 3'd1);
        end

        if (early) begin
            io_cmd_d = 1'b0;
            src_x3_d = 1'b0;
        end

        if (dec) begin
            unique case (phase_q)
                PhM1: opr_d = data_i;
                PhM2: begin
                    opa_d    = data_i;
                    io_cmd_d = cm_ram_i && (opr_q == 4'b1110);
                end
                PhX1: begin
                    if (act && (rd_main || rd_stat)) begin
                        oe_d   = 1'b1;
                        data_d = rd_main ? main_rd : stat_rd;
                    end
                end
                PhX2: begin
                    if (act) begin
                        main_we = (opa_q == 4'b0000);
                        port_we = (opa_q == 4'b0001);
                        stat_we = (opa_q[3:2] == 2'b01);
                    end
                    if (cm_ram_i) begin
                        sel_d    = (data_i[3:2] == CHIP_ID);
                        src_x3_d = 1'b1;
                        if (data_i[3:2] == CHIP_ID) ram_reg_d = data_i[1:0];
                    end
                end
                PhX3: begin
                    if (src_x3_q && sel_q) char_d = data_i;
                    src_x3_d = 1'b0;
                    io_cmd_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q   <= PhA1;
            running_q <= 1'b0;
            opr_q     <= '0;
            opa_q     <= '0;
            io_cmd_q  <= 1'b0;
            src_x3_q  <= 1'b0;
            sel_q     <= 1'b0;
            ram_reg_q <= '0;
            char_q    <= '0;
            data_q    <= '0;
            oe_q      <= 1'b0;
            port_q    <= '0;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 16; c++) main_q[r][c] <= '0;
                for (int s = 0; s < 4; s++) status_q[r][s] <= '0;
            end
        end else begin
            phase_q   <= phase_d;
            running_q <= running_d;
            opr_q     <= opr_d;
            opa_q     <= opa_d;
            io_cmd_q  <= io_cmd_d;
            src_x3_q  <= src_x3_d;
            sel_q     <= sel_d;
            ram_reg_q <= ram_reg_d;
            char_q    <= char_d;
            data_q    <= data_d;
            oe_q      <= oe_d;
            if (port_we) port_q <= data_i;
            if (main_we) main_q[ram_reg_q][char_q] <= data_i;
            if (stat_we) status_q[ram_reg_q][opa_q[1:0]] <= data_i;
        end
    end

    assign data_o  = data_q;
    assign data_oe = oe_q;
    assign port_o  = port_q;

`ifdef MCS4_RAM_DBG_PORT_EN
    assign dbg_data_o = dbg_addr_i[4] ? status_q[dbg_addr_i[6:5]][dbg_addr_i[1:0]]
                                      : main_q[dbg_addr_i[6:5]][dbg_addr_i[3:0]];
`endif

endmodule

// File: tb/tb_mcs4_ram_chip.sv
// Bench for mcs4_ram_chip: table vectors, hand-written abort/reset sequences, random instructions
// checked against an instruction-level model of the chip.
module tb_mcs4_ram_chip;

    localparam logic [1:0] CHIP = 2'd1;

    logic       clk = 1'b0;
    logic       rst;
    logic       sync_i, cm_ram_i;
    logic [3:0] data_i, data_o, port_o;
    logic       data_oe;

    always #5 clk = ~clk;

`ifdef MCS4_RAM_DBG_PORT_EN
    logic [3:0] dbg_data;
    mcs4_ram_chip #(.CHIP_ID(CHIP)) dut (
        .clk(clk), .rst(rst), .sync_i(sync_i), .cm_ram_i(cm_ram_i), .data_i(data_i),
        .data_o(data_o), .data_oe(data_oe), .port_o(port_o),
        .dbg_addr_i(7'd0), .dbg_data_o(dbg_data)
    );
`else
    mcs4_ram_chip #(.CHIP_ID(CHIP)) dut (
        .clk(clk), .rst(rst), .sync_i(sync_i), .cm_ram_i(cm_ram_i), .data_i(data_i),
        .data_o(data_o), .data_oe(data_oe), .port_o(port_o)
    );
`endif

    int vectors = 0;
    int miscompares = 0;

    // Instruction-level model of the chip contents and selection
    logic [3:0] m_main [4][16];
    logic [3:0] m_stat [4][4];
    logic [3:0] m_port, m_do, m_chr;
    logic [1:0] m_reg;
    bit         m_sel;

    // Observations of the last instruction
    bit         r_oe_x2, r_oe_other;
    logic [3:0] r_do_x2, r_port;

    typedef struct {
        logic [3:0] opr, opa, x2, x3;
        bit         cm_m2, cm_x2;
        bit         exp_oe;
        logic [3:0] exp_do, exp_port;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 16; c++) m_main[r][c] = 4'h0;
            for (int s = 0; s < 4; s++) m_stat[r][s] = 4'h0;
        end
        m_port = 4'h0;
        m_do   = 4'h0;
        m_chr  = 4'h0;
        m_reg  = 2'd0;
        m_sel  = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] opr, input logic [3:0] opa, input logic [3:0] x2,
                              input logic [3:0] x3, input bit cm_m2, input bit cm_x2,
                              output bit e_oe, output logic [3:0] e_do);
        bit io;
        io   = cm_m2 && (opr == 4'hE);
        e_oe = 1'b0;
        if (io && m_sel) begin
            if (opa == 4'h9 || opa == 4'h8 || opa == 4'hB) begin
                e_oe = 1'b1;
                m_do = m_main[m_reg][m_chr];
            end else if (opa >= 4'hC) begin
                e_oe = 1'b1;
                m_do = m_stat[m_reg][opa - 4'hC];
            end
            if (opa == 4'h0) m_main[m_reg][m_chr] = x2;
            else if (opa == 4'h1) m_port = x2;
            else if (opa >= 4'h4 && opa <= 4'h7) m_stat[m_reg][opa - 4'h4] = x2;
        end
        e_do = m_do;
        if (cm_x2) begin
            m_sel = ((x2 / 4) == CHIP);
            if (m_sel) begin
                m_reg = 2'(x2 % 4);
                m_chr = x3;
            end
        end
    endtask

    // Drives one instruction A1..X3; sync at phase sync_at (8 = no sync at all).
    task automatic instr(input logic [3:0] opr, input logic [3:0] opa, input logic [3:0] x2,
                         input logic [3:0] x3, input bit cm_m2, input bit cm_x2,
                         input int sync_at);
        logic [3:0] d;
        bit         cm;
        r_oe_x2    = 1'b0;
        r_do_x2    = 4'h0;
        r_oe_other = 1'b0;
        for (int p = 0; p < 8; p++) begin
            if (p > sync_at) break;
            d  = 4'($urandom);
            cm = 1'b0;
            case (p)
                3: d = opr;
                4: begin d = opa; cm = cm_m2; end
                6: begin d = x2; cm = cm_x2; end
                7: d = x3;
                default: ;
            endcase
            data_i   = d;
            cm_ram_i = cm;
            sync_i   = (p == sync_at);
            @(negedge clk);
            if (p == 6) begin
                r_oe_x2 = data_oe;
                r_do_x2 = data_o;
            end else if (data_oe) begin
                r_oe_other = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        sync_i = 1'b0;
        r_port = port_o;
    endtask

    task automatic sync_cycle();
        data_i   = 4'h0;
        cm_ram_i = 1'b0;
        sync_i   = 1'b1;
        @(posedge clk);
        #1;
        sync_i = 1'b0;
    endtask

    task automatic run(input string nm, input logic [3:0] opr, input logic [3:0] opa,
                       input logic [3:0] x2, input logic [3:0] x3, input bit cm_m2, input bit cm_x2);
        bit         e_oe;
        logic [3:0] e_do;
        model_step(opr, opa, x2, x3, cm_m2, cm_x2, e_oe, e_do);
        instr(opr, opa, x2, x3, cm_m2, cm_x2, 7);
        check({nm, " data_oe@X2"}, {3'b0, r_oe_x2}, {3'b0, e_oe});
        check({nm, " data_o@X2"}, r_do_x2, e_do);
        check({nm, " data_oe outside X2"}, {3'b0, r_oe_other}, 4'h0);
        check({nm, " port_o"}, r_port, m_port);
    endtask

    initial begin
        logic [3:0] opr, opa, x2, x3;
        bit         cm_m2, cm_x2, dummy_oe;
        logic [3:0] dummy_do;

        //          opr    opa    x2     x3     m2 x2  oe  do     port
        tbl[0]  = '{4'h2, 4'h1, 4'h6, 4'hA, 0, 1, 0, 4'h0, 4'h0};  // SRC chip1 reg2 char A
        tbl[1]  = '{4'hE, 4'h0, 4'h5, 4'h0, 1, 0, 0, 4'h0, 4'h0};  // WRM 5
        tbl[2]  = '{4'hE, 4'h9, 4'h0, 4'h0, 1, 0, 1, 4'h5, 4'h0};  // RDM
        tbl[3]  = '{4'hE, 4'h7, 4'hC, 4'h0, 1, 0, 0, 4'h5, 4'h0};  // WR3 C
        tbl[4]  = '{4'hE, 4'hF, 4'h0, 4'h0, 1, 0, 1, 4'hC, 4'h0};  // RD3
        tbl[5]  = '{4'hE, 4'hC, 4'h0, 4'h0, 1, 0, 1, 4'h0, 4'h0};  // RD0
        tbl[6]  = '{4'hE, 4'h1, 4'h9, 4'h0, 1, 0, 0, 4'h0, 4'h9};  // WMP 9
        tbl[7]  = '{4'hE, 4'h2, 4'h3, 4'h0, 1, 0, 0, 4'h0, 4'h9};  // WRR: port unchanged
        tbl[8]  = '{4'hE, 4'h9, 4'h0, 4'h0, 0, 0, 0, 4'h0, 4'h9};  // RDM, bank not selected
        tbl[9]  = '{4'h2, 4'h1, 4'h8, 4'hA, 0, 1, 0, 4'h0, 4'h9};  // SRC chip2
        tbl[10] = '{4'hE, 4'h0, 4'hF, 4'h0, 1, 0, 0, 4'h0, 4'h9};  // WRM F ignored
        tbl[11] = '{4'hE, 4'h9, 4'h0, 4'h0, 1, 0, 0, 4'h0, 4'h9};  // RDM ignored
        tbl[12] = '{4'h2, 4'h1, 4'h6, 4'hA, 0, 1, 0, 4'h0, 4'h9};  // SRC chip1 again
        tbl[13] = '{4'hE, 4'h9, 4'h0, 4'h0, 1, 0, 1, 4'h5, 4'h9};  // RDM still 5
        tbl[14] = '{4'hE, 4'h8, 4'h0, 4'h0, 1, 0, 1, 4'h5, 4'h9};  // SBM
        tbl[15] = '{4'hE, 4'hB, 4'h0, 4'h0, 1, 0, 1, 4'h5, 4'h9};  // ADM

        rst      = 1'b1;
        sync_i   = 1'b0;
        cm_ram_i = 1'b0;
        data_i   = 4'h0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset data_o", data_o, 4'h0);
        check("reset data_oe", {3'b0, data_oe}, 4'h0);
        check("reset port_o", port_o, 4'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // No decoding before the first sync
        instr(4'h2, 4'h1, 4'h6, 4'hA, 1'b0, 1'b1, 8);
        check("pre-sync data_oe", {3'b0, r_oe_other | r_oe_x2}, 4'h0);
        sync_cycle();

        for (int i = 0; i < 16; i++) begin
            model_step(tbl[i].opr, tbl[i].opa, tbl[i].x2, tbl[i].x3, tbl[i].cm_m2, tbl[i].cm_x2,
                       dummy_oe, dummy_do);
            instr(tbl[i].opr, tbl[i].opa, tbl[i].x2, tbl[i].x3, tbl[i].cm_m2, tbl[i].cm_x2, 7);
            check($sformatf("tbl[%0d] data_oe@X2", i), {3'b0, r_oe_x2}, {3'b0, tbl[i].exp_oe});
            check($sformatf("tbl[%0d] data_o@X2", i), r_do_x2, tbl[i].exp_do);
            check($sformatf("tbl[%0d] data_oe outside X2", i), {3'b0, r_oe_other}, 4'h0);
            check($sformatf("tbl[%0d] port_o", i), r_port, tbl[i].exp_port);
        end

        // RDM aborted by sync in X1: no drive, and the next instruction is realigned
        instr(4'hE, 4'h9, 4'h0, 4'h0, 1'b1, 1'b0, 5);
        check("X1 resync data_oe", {3'b0, r_oe_other}, 4'h0);
        run("after resync RDM", 4'hE, 4'h9, 4'h0, 4'h0, 1'b1, 1'b0);

        // WRM of 7 cut by reset in X2
        for (int p = 0; p < 6; p++) begin
            data_i   = (p == 3) ? 4'hE : (p == 4) ? 4'h0 : 4'h3;
            cm_ram_i = (p == 4);
            @(posedge clk);
            #1;
        end
        data_i   = 4'h7;
        cm_ram_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid-X2 reset data_o", data_o, 4'h0);
        check("mid-X2 reset data_oe", {3'b0, data_oe}, 4'h0);
        check("mid-X2 reset port_o", port_o, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        // Idle until sync: this SRC and RDM must not be decoded
        instr(4'h2, 4'h1, 4'h6, 4'hA, 1'b0, 1'b1, 8);
        instr(4'hE, 4'h9, 4'h0, 4'h0, 1'b1, 1'b0, 8);
        check("idle after reset data_oe", {3'b0, r_oe_other | r_oe_x2}, 4'h0);
        sync_cycle();
        run("post-reset RDM unselected", 4'hE, 4'h9, 4'h0, 4'h0, 1'b1, 1'b0);
        run("post-reset SRC", 4'h2, 4'h1, 4'h6, 4'hA, 1'b0, 1'b1);
        run("post-reset RDM cleared", 4'hE, 4'h9, 4'h0, 4'h0, 1'b1, 1'b0);
        run("post-reset RD3 cleared", 4'hE, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0);

        for (int i = 0; i < 300; i++) begin
            opr = ($urandom_range(0, 1) == 1) ? 4'hE : 4'($urandom);
            opa = 4'($urandom);
            x2  = 4'($urandom);
            if ($urandom_range(0, 3) != 0) x2[3:2] = CHIP;
            x3    = 4'($urandom);
            cm_m2 = ($urandom_range(0, 3) != 0);
            cm_x2 = ($urandom_range(0, 3) == 0);
            run($sformatf("rand[%0d] opr=%h opa=%h", i, opr, opa), opr, opa, x2, x3, cm_m2, cm_x2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
